// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl: iterative CORDIC vectoring engine with a handshake sequencer.
//
// Rotates (x_in, y_in) onto the positive x-axis over ITER cycles and returns the
// unscaled magnitude (K*|v|, K~1.64676) and the angle atan2(y, x) in Q.16 radians.
// It also drives the sel bus of the downstream holding registers: sel is 4'h0
// for exactly the first DONE cycle (the capture strobe) and 4'hF otherwise.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   engine can accept a vector (IDLE)
//   x_in/y_in  input vector, signed Q(WIDTH-17).16
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   mag_out    K*sqrt(x^2+y^2), low WIDTH bits of the internal x
//   ang_out    atan2(y, x), signed Q.16 radians
//   sel        holding-register select, 4'h0 = capture strobe
//   busy       high in ITER or DONE
module cordic_vec_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mag_out,
    output logic [WIDTH-1:0] ang_out,
    output logic [3:0]       sel,
    output logic             busy
);

    // Two guard bits absorb the CORDIC gain on x and y.
    localparam int XW = WIDTH + 2;
    localparam logic signed [WIDTH-1:0] PI = WIDTH'(205887);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t                  state, state_nx;
    logic signed [XW-1:0]    x, y, x_ext, y_ext, xs, ys, rx, ry;
    logic signed [WIDTH-1:0] z, rz, at;
    logic [4:0]              i;
    logic                    first, last;

    function automatic logic signed [WIDTH-1:0] atan_rom(input logic [4:0] k);
        case (k)
            5'd0:    atan_rom = WIDTH'(51472);
            5'd1:    atan_rom = WIDTH'(30386);
            5'd2:    atan_rom = WIDTH'(16055);
            5'd3:    atan_rom = WIDTH'(8150);
            5'd4:    atan_rom = WIDTH'(4091);
            5'd5:    atan_rom = WIDTH'(2047);
            5'd6:    atan_rom = WIDTH'(1024);
            5'd7:    atan_rom = WIDTH'(512);
            5'd8:    atan_rom = WIDTH'(256);
            5'd9:    atan_rom = WIDTH'(128);
            5'd10:   atan_rom = WIDTH'(64);
            5'd11:   atan_rom = WIDTH'(32);
            5'd12:   atan_rom = WIDTH'(16);
            5'd13:   atan_rom = WIDTH'(8);
            5'd14:   atan_rom = WIDTH'(4);
            5'd15:   atan_rom = WIDTH'(2);
            default: atan_rom = '0;
        endcase
    endfunction

    // One micro-rotation, driven toward y = 0 by the sign of the old y.
    always_comb begin
        x_ext = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext = {{2{y_in[WIDTH-1]}}, y_in};
        xs    = x >>> i;
        ys    = y >>> i;
        at    = atan_rom(i);
        rx    = y[XW-1] ? x - ys : x + ys;
        ry    = y[XW-1] ? y + xs : y - xs;
        rz    = y[XW-1] ? z - at : z + at;
        last  = (i == 5'(ITER - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = in_valid ? S_ITER : S_IDLE;
            S_ITER:  state_nx = last ? S_DONE : S_ITER;
            S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        sel       = (state == S_DONE && first) ? 4'h0 : 4'hF;
    end

    // Left-half-plane vectors are reflected through the origin and start at +/-pi,
    // so the micro-rotations only ever need to cover (-pi/2, pi/2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            i       <= '0;
            first   <= 1'b0;
            mag_out <= '0;
            ang_out <= '0;
        end else begin
            first <= (state == S_ITER) && last;
            if (state == S_IDLE && in_valid) begin
                x <= x_in[WIDTH-1] ? -x_ext : x_ext;
                y <= x_in[WIDTH-1] ? -y_ext : y_ext;
                z <= x_in[WIDTH-1] ? (y_in[WIDTH-1] ? -PI : PI) : '0;
                i <= '0;
            end else if (state == S_ITER) begin
                x <= rx;
                y <= ry;
                z <= rz;
                i <= i + 5'd1;
                if (last) begin
                    mag_out <= rx[WIDTH-1:0];
                    ang_out <= rz;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// tb_cordic_vec_ctrl: directed scoreboard bench for cordic_vec_ctrl.
module tb_cordic_vec_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] mag;
        logic [W-1:0] ang;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] x_in = '0, y_in = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] mag_out, ang_out;
    logic [3:0]   sel;

    logic         sw_valid = 1'b0, sw_rdy = 1'b1;
    logic [W-1:0] sx = '0, sy = '0;
    logic         r1, v1, b1, r4, v4, b4;
    logic [W-1:0] m1, a1, m4, a4;
    logic [3:0]   s1, s4;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cordic_vec_ctrl #(.WIDTH(W), .ITER(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .mag_out(mag_out), .ang_out(ang_out), .sel(sel), .busy(busy));

    cordic_vec_ctrl #(.WIDTH(W), .ITER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1),
        .x_in(sx), .y_in(sy), .out_valid(v1), .out_ready(sw_rdy),
        .mag_out(m1), .ang_out(a1), .sel(s1), .busy(b1));

    cordic_vec_ctrl #(.WIDTH(W), .ITER(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r4),
        .x_in(sx), .y_in(sy), .out_valid(v4), .out_ready(sw_rdy),
        .mag_out(m4), .ang_out(a4), .sel(s4), .busy(b4));

    function automatic exp_t model(input longint xi, input longint yi, input int iter);
        longint x, y, z, t;
        int     at[16];
        exp_t   e;
        at = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2};
        if (xi < 0) begin
            x = -xi;
            y = -yi;
            z = (yi >= 0) ? 205887 : -205887;
        end else begin
            x = xi;
            y = yi;
            z = 0;
        end
        for (int k = 0; k < iter; k++) begin
            t = x;
            if (y >= 0) begin
                x = x + (y >>> k);
                y = y - (t >>> k);
                z = z + at[k];
            end else begin
                x = x - (y >>> k);
                y = y + (t >>> k);
                z = z - at[k];
            end
        end
        e.mag = W'(x);
        e.ang = W'(z);
        return e;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic near(input string tag, input longint obs, input longint exp, input longint tol);
        n_chk++;
        assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic send(input longint xv, input longint yv);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        x_in     = W'(xv);
        y_in     = W'(yv);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q.push_back(model(xv, yv, 16));
    endtask

    // Waits for out_valid (counting edges after the accept edge) and checks the popped expectation.
    task automatic wait_out(input string tag, input bit chk_ang, output longint m, output longint a);
        int   n = 0;
        exp_t e;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        chk({tag, " latency"}, n, 16);
        e = q.pop_front();
        chk({tag, " mag"}, $signed(mag_out), $signed(e.mag));
        if (chk_ang) chk({tag, " ang"}, $signed(ang_out), $signed(e.ang));
        chk({tag, " sel strobe"}, sel, 4'h0);
        chk({tag, " in_ready"}, in_ready, 0);
        chk({tag, " busy"}, busy, 1);
        m = $signed(mag_out);
        a = $signed(ang_out);
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, " out_valid drop"}, out_valid, 0);
        chk({tag, " sel idle"}, sel, 4'hF);
        chk({tag, " in_ready back"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint m, a, hm, ha;
        int     stale, n, l1, l4;
        exp_t   e;

        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst mag", mag_out, 0);
        chk("rst ang", ang_out, 0);
        chk("rst sel", sel, 4'hF);
        chk("rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(65536, 0);
        wait_out("x1", 1, m, a);
        near("x1 mag tol", m, 107923, 4);
        near("x1 ang tol", a, 0, 4);
        handshake("x1");

        send(0, 65536);
        wait_out("y1", 1, m, a);
        near("y1 mag tol", m, 107923, 4);
        near("y1 ang tol", a, 102944, 8);
        handshake("y1");

        send(-65536, 0);
        wait_out("negx", 1, m, a);
        near("negx ang tol", a, 205887, 8);
        handshake("negx");

        send(-46341, -46341);
        wait_out("q3", 1, m, a);
        near("q3 mag tol", m, 107923, 8);
        near("q3 ang tol", a, -154415, 8);
        handshake("q3");

        send(0, 0);
        wait_out("zero", 0, m, a);
        handshake("zero");

        send(65536, 65536);
        wait_out("diag16", 1, m, a);
        near("diag16 ang tol", a, 51472, 4);
        handshake("diag16");

        // Consumer stalls: outputs held, strobe only in the first DONE cycle.
        out_ready = 1'b0;
        send(30000, -20000);
        wait_out("hold", 1, hm, ha);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold out_valid", out_valid, 1);
            chk("hold mag", $signed(mag_out), hm);
            chk("hold ang", $signed(ang_out), ha);
            chk("hold in_ready", in_ready, 0);
            chk("hold sel", sel, 4'hF);
        end
        x_in      = W'(1000);
        y_in      = W'(2000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs out_valid", out_valid, 0);
        chk("hs not accepted", busy, 0);
        chk("hs in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("late accept busy", busy, 1);
        q.push_back(model(1000, 2000, 16));
        wait_out("late", 1, m, a);
        handshake("late");

        // Reset in the middle of an iteration.
        send(65536, 0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = q.pop_back();
        chk("abort in_ready", in_ready, 1);
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort sel", sel, 4'hF);
        chk("abort mag", mag_out, 0);
        chk("abort ang", ang_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            stale += int'(out_valid);
            stale += int'(sel != 4'hF);
        end
        chk("no stale output", stale, 0);
        send(0, 65536);
        wait_out("post rst", 1, m, a);
        handshake("post rst");

        // ITER sweep on the narrow instances.
        sx       = W'(65536);
        sy       = W'(65536);
        sw_valid = 1'b1;
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        n  = 0;
        l1 = -1;
        l4 = -1;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (v1 && l1 < 0) l1 = n;
            if (v4 && l4 < 0) l4 = n;
        end
        chk("iter1 latency", l1, 1);
        chk("iter4 latency", l4, 4);
        chk("iter1 ang", $signed(a1), 51472);
        chk("iter1 mag", $signed(m1), 131072);
        e = model(65536, 65536, 4);
        chk("iter4 ang", $signed(a4), $signed(e.ang));
        chk("iter4 mag", $signed(m4), $signed(e.mag));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
